ps2_key_tracker: RTL and testbench

- Parametrised scancode-set-2 decoder that replaces the single-byte combinational arrow decoder.
- Consumes the byte stream from PS2Receiver (byte + 1-cycle valid strobe) and parses the E0/F0/E1 prefixes.
- Keeps a held-key bitmap for NUM_KEYS configurable keys, and emits one-cycle press/release events.
- Feeds the game control logic, so simultaneous keys (e.g. UP+LEFT) and key releases are reported correctly.

---
 rtl/ps2_key_tracker.sv | 176 +++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: scancode-set-2 parser and held-key tracker.
// Parses the PS2Receiver byte stream (E0/F0/E1 prefixes), keeps a held-key
// bitmap for NUM_KEYS configured keys and emits one-cycle press/release pulses.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx_data/valid received byte and its one-cycle strobe
//   key_held      level, bit i = key i currently down
//   key_press     one-cycle pulse on make of a key not already held
//   key_release   one-cycle pulse on break of a held key
//   last_code/last_ext/last_brk  most recent completed make/break
//   code_strobe   one-cycle pulse on every completed make/break
module ps2_key_tracker #(
  parameter int unsigned             NUM_KEYS   = 6,
  parameter logic [8*NUM_KEYS-1:0]   KEY_CODES  = {8'h76, 8'h29, 8'h74, 8'h6B, 8'h72, 8'h75},
  parameter logic [NUM_KEYS-1:0]     KEY_EXT    = 6'b001111,
  parameter bit                      STRICT_EXT = 1'b1,
  parameter logic [19:0]             TIMEOUT    = 20'd500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [7:0]          last_code,
  output logic                last_ext,
  output logic                last_brk,
  output logic                code_strobe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_e;

  localparam logic [19:0] TMO_LAST = TIMEOUT - 20'd1;

  state_e              state_q, state_d;
  logic [19:0]         tmo_q, tmo_d;
  logic [2:0]          skip_q, skip_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] rel_q, rel_d;
  logic [7:0]          code_q, code_d;
  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic                strobe_q, strobe_d;

  // Completed make/break decoded from the current byte
  logic evt, evt_ext, evt_brk;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    skip_d  = skip_q;
    evt     = 1'b0;
    evt_ext = 1'b0;
    evt_brk = 1'b0;
    if (rx_valid) begin
      // A byte always wins over a timeout expiring in the same cycle
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          case (rx_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_SKIP;
              skip_d  = 3'd7;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: ;
            default: evt = 1'b1;
          endcase
        end
        S_EXT: begin
          case (rx_data)
            8'hF0:        state_d = S_EXT_BRK;
            8'hE0, 8'h12: ;
            default: begin
              evt     = 1'b1;
              evt_ext = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          evt     = 1'b1;
          evt_brk = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          // Fake-shift break (E0 F0 12) is swallowed silently
          if (rx_data != 8'h12) begin
            evt     = 1'b1;
            evt_ext = 1'b1;
            evt_brk = 1'b1;
          end
          state_d = S_IDLE;
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 20'd1;
      end
    end
  end

  always_comb begin
    held_d   = held_q;
    press_d  = '0;
    rel_d    = '0;
    strobe_d = evt;
    code_d   = evt ? rx_data : code_q;
    ext_d    = evt ? evt_ext : ext_q;
    brk_d    = evt ? evt_brk : brk_q;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (evt && (KEY_CODES[8*i +: 8] == rx_data) &&
          (!STRICT_EXT || (evt_ext == KEY_EXT[i]))) begin
        if (evt_brk) begin
          held_d[i] = 1'b0;
          rel_d[i]  = held_q[i];
        end else begin
          held_d[i]  = 1'b1;
          press_d[i] = ~held_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      skip_q   <= '0;
      held_q   <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      code_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      skip_q   <= skip_d;
      held_q   <= held_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      code_q   <= code_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      strobe_q <= strobe_d;
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign last_code   = code_q;
  assign last_ext    = ext_q;
  assign last_brk    = brk_q;
  assign code_strobe = strobe_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: table of byte vectors with expected
// outputs, plus hand-written timeout, reset and non-strict sequences.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic [5:0] s_held, s_press, s_rel;
  logic [7:0] s_code;
  logic       s_ext, s_brk, s_strb;
  logic [5:0] l_held, l_press, l_rel;
  logic [7:0] l_code;
  logic       l_ext, l_brk, l_strb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT(20'd16)) u_strict (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_held(s_held), .key_press(s_press), .key_release(s_rel),
    .last_code(s_code), .last_ext(s_ext), .last_brk(s_brk), .code_strobe(s_strb)
  );

  ps2_key_tracker #(.STRICT_EXT(1'b0), .TIMEOUT(20'd16)) u_loose (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_held(l_held), .key_press(l_press), .key_release(l_rel),
    .last_code(l_code), .last_ext(l_ext), .last_brk(l_brk), .code_strobe(l_strb)
  );

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [5:0] held;
    logic [5:0] press;
    logic [5:0] rel;
    logic       strb;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] d, input logic v, input logic [5:0] h,
                     input logic [5:0] p, input logic [5:0] r, input logic s,
                     input logic [7:0] c, input logic e, input logic b);
    vec_t t;
    t.d = d; t.v = v; t.held = h; t.press = p; t.rel = r;
    t.strb = s; t.code = c; t.ext = e; t.brk = b;
    vecs.push_back(t);
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge
  task automatic send(input logic [7:0] d, input logic v);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(8'h00, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] h, input logic [5:0] p,
                         input logic [5:0] r, input logic s, input logic [7:0] c,
                         input logic e, input logic b);
    chk({tag, " held"},   32'(s_held),  32'(h));
    chk({tag, " press"},  32'(s_press), 32'(p));
    chk({tag, " rel"},    32'(s_rel),   32'(r));
    chk({tag, " strobe"}, 32'(s_strb),  32'(s));
    chk({tag, " code"},   32'(s_code),  32'(c));
    chk({tag, " ext"},    32'(s_ext),   32'(e));
    chk({tag, " brk"},    32'(s_brk),   32'(b));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send(8'h00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    //   byte   v     held    press   rel     s     code   e     b
    add(8'hE0, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h75, 1'b1, 6'h01, 6'h01, 6'h00, 1'b1, 8'h75, 1'b1, 1'b0);
    add(8'hE0, 1'b1, 6'h01, 6'h00, 6'h00, 1'b0, 8'h75, 1'b1, 1'b0);
    add(8'hF0, 1'b1, 6'h01, 6'h00, 6'h00, 1'b0, 8'h75, 1'b1, 1'b0);
    add(8'h75, 1'b1, 6'h00, 6'h00, 6'h01, 1'b1, 8'h75, 1'b1, 1'b1);
    // typematic LEFT x3, then UP chord
    add(8'hE0, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b1, 1'b1);
    add(8'h6B, 1'b1, 6'h04, 6'h04, 6'h00, 1'b1, 8'h6B, 1'b1, 1'b0);
    add(8'hE0, 1'b1, 6'h04, 6'h00, 6'h00, 1'b0, 8'h6B, 1'b1, 1'b0);
    add(8'h6B, 1'b1, 6'h04, 6'h00, 6'h00, 1'b1, 8'h6B, 1'b1, 1'b0);
    add(8'hE0, 1'b1, 6'h04, 6'h00, 6'h00, 1'b0, 8'h6B, 1'b1, 1'b0);
    add(8'h6B, 1'b1, 6'h04, 6'h00, 6'h00, 1'b1, 8'h6B, 1'b1, 1'b0);
    add(8'hE0, 1'b1, 6'h04, 6'h00, 6'h00, 1'b0, 8'h6B, 1'b1, 1'b0);
    add(8'h75, 1'b1, 6'h05, 6'h01, 6'h00, 1'b1, 8'h75, 1'b1, 1'b0);
    // release both
    add(8'hE0, 1'b1, 6'h05, 6'h00, 6'h00, 1'b0, 8'h75, 1'b1, 1'b0);
    add(8'hF0, 1'b1, 6'h05, 6'h00, 6'h00, 1'b0, 8'h75, 1'b1, 1'b0);
    add(8'h75, 1'b1, 6'h04, 6'h00, 6'h01, 1'b1, 8'h75, 1'b1, 1'b1);
    add(8'hE0, 1'b1, 6'h04, 6'h00, 6'h00, 1'b0, 8'h75, 1'b1, 1'b1);
    add(8'hF0, 1'b1, 6'h04, 6'h00, 6'h00, 1'b0, 8'h75, 1'b1, 1'b1);
    add(8'h6B, 1'b1, 6'h00, 6'h00, 6'h04, 1'b1, 8'h6B, 1'b1, 1'b1);
    // keypad 8 (non-extended 75) must not match UP
    add(8'h75, 1'b1, 6'h00, 6'h00, 6'h00, 1'b1, 8'h75, 1'b0, 1'b0);
    // ignored byte and an idle cycle
    add(8'hAA, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'h00, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    // Pause sequence is swallowed, then SPACE proves IDLE
    add(8'hE1, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'h14, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'h77, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'hE1, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'hF0, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'h14, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'hF0, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'h77, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 8'h75, 1'b0, 1'b0);
    add(8'h29, 1'b1, 6'h10, 6'h10, 6'h00, 1'b1, 8'h29, 1'b0, 1'b0);
    // fake shift make and break
    add(8'hE0, 1'b1, 6'h10, 6'h00, 6'h00, 1'b0, 8'h29, 1'b0, 1'b0);
    add(8'h12, 1'b1, 6'h10, 6'h00, 6'h00, 1'b0, 8'h29, 1'b0, 1'b0);
    add(8'hE0, 1'b1, 6'h10, 6'h00, 6'h00, 1'b0, 8'h29, 1'b0, 1'b0);
    add(8'h74, 1'b1, 6'h18, 6'h08, 6'h00, 1'b1, 8'h74, 1'b1, 1'b0);
    add(8'hE0, 1'b1, 6'h18, 6'h00, 6'h00, 1'b0, 8'h74, 1'b1, 1'b0);
    add(8'hF0, 1'b1, 6'h18, 6'h00, 6'h00, 1'b0, 8'h74, 1'b1, 1'b0);
    add(8'h12, 1'b1, 6'h18, 6'h00, 6'h00, 1'b0, 8'h74, 1'b1, 1'b0);
    add(8'hE0, 1'b1, 6'h18, 6'h00, 6'h00, 1'b0, 8'h74, 1'b1, 1'b0);
    add(8'hF0, 1'b1, 6'h18, 6'h00, 6'h00, 1'b0, 8'h74, 1'b1, 1'b0);
    add(8'h74, 1'b1, 6'h10, 6'h00, 6'h08, 1'b1, 8'h74, 1'b1, 1'b1);
    // break of a key not held: no release pulse
    add(8'hF0, 1'b1, 6'h10, 6'h00, 6'h00, 1'b0, 8'h74, 1'b1, 1'b1);
    add(8'h76, 1'b1, 6'h10, 6'h00, 6'h00, 1'b1, 8'h76, 1'b0, 1'b1);
    add(8'hF0, 1'b1, 6'h10, 6'h00, 6'h00, 1'b0, 8'h76, 1'b0, 1'b1);
    add(8'h29, 1'b1, 6'h00, 6'h00, 6'h10, 1'b1, 8'h29, 1'b0, 1'b1);

    // reset state
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk_all("reset", 6'h00, 6'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // consecutive rows keep rx_valid high on back-to-back cycles
    foreach (vecs[i]) begin
      rx_data  = vecs[i].d;
      rx_valid = vecs[i].v;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].held, vecs[i].press, vecs[i].rel,
              vecs[i].strb, vecs[i].code, vecs[i].ext, vecs[i].brk);
    end
    rx_valid = 1'b0;

    // timeout well past expiry: 29 is a plain SPACE make
    send(8'hE0, 1'b1);
    idle(20);
    chk("tmo idle strobe", 32'(s_strb), 32'd0);
    send(8'h29, 1'b1);
    chk_all("tmo late", 6'h10, 6'h10, 6'h00, 1'b1, 8'h29, 1'b0, 1'b0);
    send(8'hF0, 1'b1);
    send(8'h29, 1'b1);
    chk("tmo clr", 32'(s_held), 32'h00);

    // byte on the expiry cycle is still extended
    send(8'hE0, 1'b1);
    idle(15);
    send(8'h74, 1'b1);
    chk_all("tmo edge", 6'h08, 6'h08, 6'h00, 1'b1, 8'h74, 1'b1, 1'b0);
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h74, 1'b1);
    chk("tmo edge clr", 32'(s_held), 32'h00);

    // one cycle after expiry the prefix is gone
    send(8'hE0, 1'b1);
    idle(16);
    send(8'h74, 1'b1);
    chk_all("tmo past", 6'h00, 6'h00, 6'h00, 1'b1, 8'h74, 1'b0, 1'b0);

    // reset mid-sequence discards the pending F0
    send(8'h76, 1'b1);
    send(8'hE0, 1'b1);
    send(8'h75, 1'b1);
    chk("rst pre held", 32'(s_held), 32'h21);
    send(8'hF0, 1'b1);
    do_reset();
    chk_all("rst mid", 6'h00, 6'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h76, 1'b1);
    chk_all("rst after", 6'h20, 6'h20, 6'h00, 1'b1, 8'h76, 1'b0, 1'b0);

    // non-strict instance: keypad 8 counts as UP
    do_reset();
    send(8'h75, 1'b1);
    chk("loose held", 32'(l_held), 32'h01);
    chk("loose press", 32'(l_press), 32'h01);
    chk("loose ext", 32'(l_ext), 32'd0);
    chk("strict held", 32'(s_held), 32'h00);
    send(8'h00, 1'b0);
    chk("loose press width", 32'(l_press), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
